gat_stage_scheduler: RTL

GAT_STAGE_SCHEDULER -- requirements
Module: gat_stage_scheduler

---
 rtl/gat_stage_scheduler.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/gat_stage_scheduler.sv
// GAT layer stage scheduler: per node block, sequences SPMM -> DMVM -> SOFTMAX -> AGGR with a per-stage watchdog.
// Optional per-stage busy-cycle counters are built only when GAT_SCHED_PERF_EN is defined.
module gat_stage_scheduler #(
   parameter int BLK_W     = 16,
   parameter int TIMEOUT_W = 20
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic [BLK_W-1:0]     num_blk_i,
   output logic [3:0]           stage_start_o,
   input  logic [3:0]           stage_done_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic [BLK_W-1:0]     blk_idx_o,
   output logic [31:0]          status_o,
   output logic [3:0][31:0]     stage_cyc_o
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SPMM = 3'd1,
      S_DMVM = 3'd2,
      S_SM   = 3'd3,
      S_AGGR = 3'd4,
      S_DONE = 3'd5,
      S_ERR  = 3'd6
   } state_t;

   localparam logic [TIMEOUT_W-1:0] WDOG_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

   state_t               state_q;
   logic [BLK_W-1:0]     num_blk_q;
   logic [BLK_W-1:0]     blk_idx_q;
   logic [TIMEOUT_W-1:0] wdog_q;
   logic [3:0]           stage_start_q;
   logic                 done_q;
   logic                 err_q;
   logic                 busy_q;
   logic                 done_seen_q;

   logic [3:0] active_oh;
   logic       in_stage;
   logic       start_ok;
   logic       done_acc;
   logic       wdog_exp;
   logic       last_blk;

   always_comb begin
      active_oh = 4'b0000;
      case (state_q)
         S_SPMM:  active_oh = 4'b0001;
         S_DMVM:  active_oh = 4'b0010;
         S_SM:    active_oh = 4'b0100;
         S_AGGR:  active_oh = 4'b1000;
         default: active_oh = 4'b0000;
      endcase
      in_stage = |active_oh;
      start_ok = start_i && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
      // A done in the launch-pulse cycle belongs to a previous launch and is dropped.
      done_acc = in_stage && (|(stage_done_i & active_oh)) && (stage_start_q == 4'b0000);
      wdog_exp = in_stage && !done_acc && (wdog_q == WDOG_LAST);
      last_blk = (blk_idx_q == (num_blk_q - BLK_W'(1)));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         num_blk_q     <= '0;
         blk_idx_q     <= '0;
         wdog_q        <= '0;
         stage_start_q <= 4'b0000;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         busy_q        <= 1'b0;
         done_seen_q   <= 1'b0;
      end else begin
         stage_start_q <= 4'b0000;
         done_q        <= 1'b0;
         if (in_stage) wdog_q <= wdog_q + TIMEOUT_W'(1);
         case (state_q)
            S_SPMM, S_DMVM, S_SM, S_AGGR: begin
               if (done_acc) begin
                  wdog_q <= '0;
                  case (state_q)
                     S_SPMM: begin
                        state_q       <= S_DMVM;
                        stage_start_q <= 4'b0010;
                     end
                     S_DMVM: begin
                        state_q       <= S_SM;
                        stage_start_q <= 4'b0100;
                     end
                     S_SM: begin
                        state_q       <= S_AGGR;
                        stage_start_q <= 4'b1000;
                     end
                     default: begin
                        if (last_blk) begin
                           state_q     <= S_DONE;
                           done_q      <= 1'b1;
                           done_seen_q <= 1'b1;
                           busy_q      <= 1'b0;
                        end else begin
                           blk_idx_q     <= blk_idx_q + BLK_W'(1);
                           state_q       <= S_SPMM;
                           stage_start_q <= 4'b0001;
                        end
                     end
                  endcase
               end else if (wdog_exp) begin
                  state_q <= S_ERR;
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               if (start_ok) begin
                  num_blk_q   <= num_blk_i;
                  blk_idx_q   <= '0;
                  err_q       <= 1'b0;
                  wdog_q      <= '0;
                  done_seen_q <= 1'b0;
                  if (num_blk_i == '0) begin
                     state_q     <= S_DONE;
                     done_q      <= 1'b1;
                     done_seen_q <= 1'b1;
                     busy_q      <= 1'b0;
                  end else begin
                     state_q       <= S_SPMM;
                     stage_start_q <= 4'b0001;
                     busy_q        <= 1'b1;
                  end
               end else if (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR) begin
                  state_q <= state_q;
               end else begin
                  state_q <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign stage_start_o = stage_start_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign err_o         = err_q;
   assign blk_idx_o     = blk_idx_q;
   assign status_o      = {20'b0, err_q, busy_q, done_seen_q, state_q, active_oh, 2'b00};

`ifdef GAT_SCHED_PERF_EN
   logic [3:0][31:0] cyc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q <= '0;
      end else if (start_ok) begin
         cyc_q <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (active_oh[i] && (cyc_q[i] != 32'hFFFF_FFFF)) cyc_q[i] <= cyc_q[i] + 32'd1;
         end
      end
   end

   assign stage_cyc_o = cyc_q;
`else
   assign stage_cyc_o = '0;
`endif

endmodule
